rgb_mixer_multi: RTL
====================

// Module: rgb_mixer_multi
// PURPOSE
//   NUM_CH-channel encoder-to-PWM mixer: the generalised successor of the 3-channel RGB mixer.
//   Per channel: rotary quadrature inputs -> 2-FF synchroniser -> history debouncer -> quadrature
//   decoder -> WIDTH-bit level register -> PWM output.
//   Adds wrap/saturate mode, a preset-load port, a level readout bus and period-aligned
//   (glitch-free) PWM level update.
// PARAMETERS
//   NUM_CH    3  number of channels (>=1)
//   WIDTH     8  level / PWM counter width (>=2)
//   HIST_LEN  8  debounce history length in clk samples (>=2)
//   SATURATE  1  1: clamp level at 0 and 2^WIDTH-1; 0: wrap modulo 2^WIDTH
//   LCH_W     $clog2(NUM_CH) (min 1)  width of load_ch
// PORTS
//   clk        in   1              system clock, all state on rising edge
//   reset      in   1              asynchronous, active-low reset
//   enc_a      in   NUM_CH         encoder A phase, bit i = channel i (async to clk)
//   enc_b      in   NUM_CH         encoder B phase, bit i = channel i (async to clk)
//   load       in   1              1-cycle strobe: preset level of channel load_ch
//   load_ch    in   LCH_W          channel index for load
//   load_val   in   WIDTH          preset value for load
//   level      out  NUM_CH*WIDTH   current level registers, channel i at [i*WIDTH +: WIDTH]
//   pwm_out    out  NUM_CH         PWM outputs
//   period_sot out  1              high while the shared PWM counter == 0
// BEHAVIOUR
//   Reset (reset=0, async): sync FFs, history, debounced and prev-state bits = 0.
//     Level registers = 0, PWM level buffers = 0, counter = 0, pwm_out = 0, period_sot = 1.
//   Sync: two FFs per input bit; no logic between them.
//   Debounce: hist <= {hist[HIST_LEN-2:0], sync_out}.
//     db <= 1 if next hist all ones; db <= 0 if next hist all zeros; else db holds.
//   Decode: db_prev <= db each cycle; the (prev,cur) pair of {a,b} gives the step.
//     00->01->11->10->00 = +1; the reverse sequence = -1.
//     No change, or both bits changing at once = 0 (illegal, ignored, no error).
//   Latency: a clean input change updates level on the (HIST_LEN+3)th rising clk edge after
//     the change (11 edges at HIST_LEN=8). Glitches shorter than HIST_LEN samples never
//     reach db.
//   Arithmetic: WIDTH-bit unsigned.
//     SATURATE=1: +1 at max holds max; -1 at 0 holds 0.
//     SATURATE=0: max+1 -> 0; 0-1 -> max.
//   Load: when load=1 and load_ch<NUM_CH, level[load_ch] <= load_val on that edge.
//     Load has priority over a decoder step on the same channel in the same cycle (step lost).
//     load_ch>=NUM_CH: ignored. Other channels step normally in the load cycle.
//   PWM: one shared free-running WIDTH-bit counter cnt, 0..2^WIDTH-1 then wraps to 0.
//     Per-channel lvl_buf <= level on the edge where cnt == 2^WIDTH-1, so a new level takes
//     effect from cnt==0. No mid-period change.
//     pwm_out[i] = (cnt < lvl_buf[i]), decoded from registers only.
//     Level 0 gives constant 0; level L gives L high cycles per 2^WIDTH-cycle period,
//     starting at cnt==0.
//   period_sot = (cnt == 0).
//   Reset mid-operation: immediate async clear of all state. Counting resumes from cnt=0 on
//     the first edge after release.
//   Channels are fully independent except for the shared cnt.
// TESTING
//   1 Reset: drive reset=0 mid-PWM period -> level=0, pwm_out=0 and period_sot=1
//     immediately without a clk edge. After release, cnt counts 0,1,2...
//   2 Step + latency: ch0 {a,b} 00->01 held -> level[ch0] 0->1 exactly on edge 11
//     (HIST_LEN=8).
//     Full reverse cycle 4 steps -> back to 0. Ch1/ch2 levels unchanged throughout.
//   3 Debounce: pulse enc_a=1 for 7 cycles then 0 -> no level change.
//     Hold 8 cycles -> change.
//     Both bits flipping simultaneously (00->11) -> no change.
//   4 Limits: load 255 then +1. SATURATE=1 -> 255; SATURATE=0 -> 0.
//     From 0, -1: SATURATE=1 -> 0; SATURATE=0 -> 255.
//   5 Load: load=1, load_ch=2, load_val=0x80 on the same edge as a +1 decoder step on ch2
//     -> level[ch2]=0x80. load_ch=3 with NUM_CH=3 -> no channel changes.
//   6 PWM: level 64 loaded mid-period -> first full period after the next cnt wrap has
//     pwm_out high for exactly 64 of 256 cycles, starting at cnt=0 (period_sot=1).
//     Level 0 -> never high. Level 255 -> low only at cnt=255.

Source files
------------

// File: rtl/rgb_mixer_multi.sv
// rgb_mixer_multi
//   Multi-channel encoder-to-PWM mixer. Each channel takes a rotary quadrature
//   encoder (enc_a/enc_b), synchronises it with two flops, debounces it against
//   a sample history, decodes quadrature steps into a WIDTH-bit level register,
//   and drives a PWM output from a shared free-running counter. The PWM level is
//   buffered once per period so a new level never changes a period that is
//   already in progress.
//
// Ports
//   clk         system clock; all state changes on the rising edge
//   reset       asynchronous, active-low reset
//   enc_a/enc_b encoder phases, bit i belongs to channel i (asynchronous to clk)
//   load        single-cycle strobe that presets the level of channel load_ch
//   load_ch     channel index for load; values >= NUM_CH are ignored
//   load_val    preset value for load
//   level       current level registers, channel i at [i*WIDTH +: WIDTH]
//   pwm_out     PWM outputs, one per channel
//   period_sot  high while the shared PWM counter is 0 (start of period)

module rgb_mixer_multi #(
  parameter int NUM_CH   = 3,
  parameter int WIDTH    = 8,
  parameter int HIST_LEN = 8,
  parameter bit SATURATE = 1'b1,
  parameter int LCH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       enc_a,
  input  logic [NUM_CH-1:0]       enc_b,
  input  logic                    load,
  input  logic [LCH_W-1:0]        load_ch,
  input  logic [WIDTH-1:0]        load_val,
  output logic [NUM_CH*WIDTH-1:0] level,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_sot
);

  localparam logic [WIDTH-1:0] LVL_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] cnt;
  logic             cnt_wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  assign cnt_wrap   = (cnt == LVL_MAX);
  assign period_sot = (cnt == '0);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic                a_s1, a_s2, b_s1, b_s2;
    // Only the newest HIST_LEN-1 samples are stored; the incoming synchronised
    // sample completes the HIST_LEN-wide window that the debouncer inspects.
    logic [HIST_LEN-2:0] hist_a, hist_b;
    logic [HIST_LEN-1:0] win_a, win_b;
    logic                db_a, db_b, prev_a, prev_b;
    logic                step_up, step_dn, load_hit;
    logic [WIDTH-1:0]    lvl, lvl_buf;

    assign win_a    = {hist_a, a_s2};
    assign win_b    = {hist_b, b_s2};
    assign load_hit = load && (load_ch == LCH_W'(i));

    // Gray-code step decode on {prev_a, prev_b, db_a, db_b}. Double-bit
    // changes fall through as no step.
    always_comb begin
      step_up = 1'b0;
      step_dn = 1'b0;
      case ({prev_a, prev_b, db_a, db_b})
        4'b0001, 4'b0111, 4'b1110, 4'b1000: step_up = 1'b1;
        4'b0100, 4'b1101, 4'b1011, 4'b0010: step_dn = 1'b1;
        default: ;
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        a_s1    <= 1'b0;
        a_s2    <= 1'b0;
        b_s1    <= 1'b0;
        b_s2    <= 1'b0;
        hist_a  <= '0;
        hist_b  <= '0;
        db_a    <= 1'b0;
        db_b    <= 1'b0;
        prev_a  <= 1'b0;
        prev_b  <= 1'b0;
        lvl     <= '0;
        lvl_buf <= '0;
      end else begin
        a_s1   <= enc_a[i];
        a_s2   <= a_s1;
        b_s1   <= enc_b[i];
        b_s2   <= b_s1;
        hist_a <= win_a[HIST_LEN-2:0];
        hist_b <= win_b[HIST_LEN-2:0];

        if (&win_a)       db_a <= 1'b1;
        else if (~|win_a) db_a <= 1'b0;
        if (&win_b)       db_b <= 1'b1;
        else if (~|win_b) db_b <= 1'b0;

        prev_a <= db_a;
        prev_b <= db_b;

        // A preset wins over a decoder step landing in the same cycle.
        if (load_hit) begin
          lvl <= load_val;
        end else if (step_up) begin
          if (!(SATURATE && (lvl == LVL_MAX))) lvl <= lvl + WIDTH'(1);
        end else if (step_dn) begin
          if (!(SATURATE && (lvl == '0)))      lvl <= lvl - WIDTH'(1);
        end

        // Capture on the last count so the new level applies from cnt == 0.
        if (cnt_wrap) lvl_buf <= lvl;
      end
    end

    assign level[i*WIDTH +: WIDTH] = lvl;
    assign pwm_out[i]              = (cnt < lvl_buf);
  end

endmodule
